// File: rtl/gsensor_spi_responder.sv
// SPI mode-3 responder emulating an accelerometer register file (DEVID, rate/power/format, XYZ samples).
// Latency: sdo updates SYNC_STAGES+1 clk after each sclk fall; writes commit 1 clk after the 8th data-bit rise.
// No backpressure: the initiator paces everything; sclk must be at most clk/8.
module gsensor_spi_responder #(
   parameter logic [7:0] DEVID       = 8'hE5,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sclk,
   input  logic        cs_n,
   input  logic        sdi,
   output logic        sdo,
   output logic        sdo_oe,
   input  logic [15:0] sample_x,
   input  logic [15:0] sample_y,
   input  logic [15:0] sample_z,
   output logic        wr_valid,
   output logic [5:0]  wr_addr,
   output logic [7:0]  wr_data,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync;
   logic       sclk_s, cs_s, sdi_s, sclk_prev;
   logic       sclk_rise, sclk_fall;

   logic [2:0] bit_cnt;
   logic [2:0] fall_cnt;
   logic [7:0] rx;
   logic [7:0] rx_byte;
   logic [7:0] tx;
   logic       rw, mb;
   logic [5:0] addr;
   logic       sdo_r, oe_r;

   logic       commit_pend;
   logic [5:0] commit_addr;
   logic [7:0] commit_data;
   logic       commit_ok;

   logic [15:0] snap_x, snap_y, snap_z;
   logic [7:0]  bw_rate, power_ctl, data_format;
   logic [7:0]  rd_dat;

   assign sclk_s  = sclk_sync[SYNC_STAGES-1];
   assign cs_s    = cs_sync[SYNC_STAGES-1];
   assign sdi_s   = sdi_sync[SYNC_STAGES-1];

   // sclk edges count only while the chip is selected
   assign sclk_rise = sclk_s & ~sclk_prev & ~cs_s;
   assign sclk_fall = ~sclk_s & sclk_prev & ~cs_s;

   assign rx_byte   = {rx[6:0], sdi_s};
   assign commit_ok = (commit_addr == 6'h2C) || (commit_addr == 6'h2D) || (commit_addr == 6'h31);

   assign busy   = (state != IDLE);
   assign sdo_oe = oe_r;
   assign sdo    = sdo_r & oe_r;

   // Synchronize the SPI pins; idle values are sclk=1, cs_n=1, sdi=0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync <= '1;
         cs_sync   <= '1;
         sdi_sync  <= '0;
         sclk_prev <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
         sclk_prev <= sclk_s;
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next state: deselect always returns to IDLE, command ends on the 8th rise
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!cs_s) state_nxt = CMD;
         CMD: begin
            if (cs_s)                              state_nxt = IDLE;
            else if (sclk_rise && bit_cnt == 3'd7) state_nxt = DATA;
         end
         DATA:    if (cs_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Register read mux, axis bytes come from the per-transaction snapshot
   always_comb begin
      rd_dat = 8'h00;
      case (addr)
         6'h00:   rd_dat = DEVID;
         6'h2C:   rd_dat = bw_rate;
         6'h2D:   rd_dat = power_ctl;
         6'h31:   rd_dat = data_format;
         6'h32:   rd_dat = snap_x[7:0];
         6'h33:   rd_dat = snap_x[15:8];
         6'h34:   rd_dat = snap_y[7:0];
         6'h35:   rd_dat = snap_y[15:8];
         6'h36:   rd_dat = snap_z[7:0];
         6'h37:   rd_dat = snap_z[15:8];
         default: rd_dat = 8'h00;
      endcase
   end

   // Shift datapath, write commit and register file
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt     <= 3'd0;
         fall_cnt    <= 3'd0;
         rx          <= 8'h00;
         tx          <= 8'h00;
         rw          <= 1'b0;
         mb          <= 1'b0;
         addr        <= 6'h00;
         sdo_r       <= 1'b0;
         oe_r        <= 1'b0;
         commit_pend <= 1'b0;
         commit_addr <= 6'h00;
         commit_data <= 8'h00;
         wr_valid    <= 1'b0;
         wr_addr     <= 6'h00;
         wr_data     <= 8'h00;
         snap_x      <= 16'h0000;
         snap_y      <= 16'h0000;
         snap_z      <= 16'h0000;
         bw_rate     <= 8'h0A;
         power_ctl   <= 8'h00;
         data_format <= 8'h00;
      end else begin
         wr_valid <= 1'b0;
         if (commit_pend) begin
            commit_pend <= 1'b0;
            if (commit_ok) begin
               wr_valid <= 1'b1;
               wr_addr  <= commit_addr;
               wr_data  <= commit_data;
               case (commit_addr)
                  6'h2C:   bw_rate     <= commit_data;
                  6'h2D:   power_ctl   <= commit_data;
                  6'h31:   data_format <= commit_data;
                  default: ;
               endcase
            end
         end

         case (state)
            IDLE: begin
               sdo_r <= 1'b0;
               oe_r  <= 1'b0;
               if (!cs_s) begin
                  snap_x   <= sample_x;
                  snap_y   <= sample_y;
                  snap_z   <= sample_z;
                  bit_cnt  <= 3'd0;
                  fall_cnt <= 3'd0;
                  rx       <= 8'h00;
               end
            end
            CMD: begin
               sdo_r <= 1'b0;
               oe_r  <= 1'b0;
               if (sclk_rise) begin
                  rx      <= rx_byte;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     rw       <= rx_byte[7];
                     mb       <= rx_byte[6];
                     addr     <= rx_byte[5:0];
                     fall_cnt <= 3'd0;
                  end
               end
            end
            DATA: begin
               if (cs_s) begin
                  sdo_r <= 1'b0;
                  oe_r  <= 1'b0;
               end else begin
                  if (sclk_fall && rw) begin
                     oe_r     <= 1'b1;
                     fall_cnt <= fall_cnt + 3'd1;
                     if (fall_cnt == 3'd0) begin
                        sdo_r <= rd_dat[7];
                        tx    <= {rd_dat[6:0], 1'b0};
                     end else begin
                        sdo_r <= tx[7];
                        tx    <= {tx[6:0], 1'b0};
                     end
                  end
                  if (sclk_rise) begin
                     rx      <= rx_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (!rw) begin
                           commit_pend <= 1'b1;
                           commit_addr <= addr;
                           commit_data <= rx_byte;
                        end
                        if (mb) addr <= addr + 6'd1;
                     end
                  end
               end
            end
            default: begin
               sdo_r <= 1'b0;
               oe_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule
